cpu_run_ctrl: RTL and testbench
===============================

# cpu_run_ctrl

Run controller that sequences the pipelined CPU core through one complete program execution. It accepts a start request with an operand, holds the CPU in reset, releases it, and gates `en`. It detects program completion by a halt PC or by a cycle timeout, drains the pipeline, and captures `ANS0`/`ANS1` into stable result registers. It sits between the top-level test/host logic and the CPU's `rst`, `en`, `number`, `PC`, `ANS0` and `ANS1` pins.

## Interface
Parameters:
- `HALT_PC`, 32'h0000_0040: fetch PC value that marks program end.
- `RST_CYCLES`, 2: cycles `cpu_rst` is held after start acceptance; must be ≥1.
- `DRAIN_CYCLES`, 5: enabled cycles after halt detection before capture, which empties the 4-stage pipeline; must be ≥1.
- `MAX_CYCLES`, 4096: enabled RUN cycles before timeout; must be ≤ 2^`CNT_W`.
- `CNT_W`, 16: width of the cycle counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset of this block.
- `start` in 1: run request; accepted only in IDLE.
- `abort` in 1: cancels the run in progress.
- `number_in` in 32: operand for the run; latched on start acceptance.
- `step_mode` in 1: 1 = CPU advances only on `step` pulses.
- `step` in 1: single-step strobe; used only when `step_mode`=1.
- `cpu_pc` in 32: CPU fetch PC.
- `cpu_ans0` in 32: CPU ANS0 output.
- `cpu_ans1` in 32: CPU ANS1 output.
- `cpu_rst` out 1: reset to the CPU.
- `cpu_en` out 1: enable to the CPU.
- `cpu_number` out 32: operand to the CPU.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `timeout` out 1: run ended by timeout; valid with `done` and held until the next start.
- `ans0` out 32: captured result 0.
- `ans1` out 32: captured result 1.
- `cycles` out `CNT_W`: enabled RUN cycles of the last or current run.

## Operation
- States: IDLE, CRST, RUN, DRAIN, DONE.
- Reset values: state=IDLE, `cpu_rst`=1, `cpu_en`=0, `cpu_number`=0, `busy`=0, `done`=0, `timeout`=0, `ans0`=`ans1`=0, `cycles`=0, internal counters=0.
- **IDLE**
  - `cpu_rst`=1.
  - `start`=1 takes effect at the clock edge: latch `number_in` into `cpu_number`, clear `cycles` and `timeout`, load the reset counter, then go to CRST.
  - `abort` is ignored in IDLE.
- **CRST**
  - `cpu_rst`=1 for exactly `RST_CYCLES` cycles, then go to RUN.
- **RUN**
  - `cpu_rst`=0.
  - `cpu_en` = `!step_mode | step`; this is combinational from the registered state.
  - Each cycle with `cpu_en`=1 increments `cycles`.
  - Halt: `cpu_pc`==`HALT_PC`, sampled every RUN cycle whether or not `cpu_en` is high. On halt, go to DRAIN with `timeout`=0.
  - Timeout: an enabled cycle with `cycles`==`MAX_CYCLES`-1 and no halt. On timeout, `cycles` goes to `MAX_CYCLES` (wraps to 0 if `MAX_CYCLES`=2^`CNT_W`), `timeout`:=1, and the state goes to DRAIN.
  - Halt and timeout in the same cycle: halt wins and `timeout` stays 0.
- **DRAIN**
  - `cpu_en` follows the same rule as RUN.
  - The block counts `DRAIN_CYCLES` enabled cycles; `cycles` does not increment.
  - On the edge of the last enabled drain cycle, latch `cpu_ans0`/`cpu_ans1` into `ans0`/`ans1` and go to DONE.
- **DONE**
  - One cycle with `done`=1, `cpu_en`=0 and `cpu_rst`=0, then go to IDLE.
- **Abort**
  - `abort`=1 in CRST, RUN or DRAIN: go to IDLE at the next edge.
  - No `done` pulse; `ans0`, `ans1` and `timeout` keep their previous values.
  - `cycles` freezes.
  - `abort` in DONE is ignored.
- **Start while busy:** ignored, with no queuing.
- **Reset priority:** `rst` overrides everything, including mid-run; all outputs return to their reset values at the next edge.
- **Held values:** `ans0`, `ans1`, `cycles`, `timeout` and `cpu_number` hold until the next accepted start. `cpu_number` stays stable for the whole run.

## Timing
- All outputs are registered except `cpu_en`, which is decoded from state, `step_mode` and `step` with no added register.
- `start` sampled at edge T:
  - `busy`=1 and `cpu_rst`=1 from T+1 through T+`RST_CYCLES`.
  - RUN begins at T+`RST_CYCLES`+1, when `cpu_rst` falls.
- Halt seen in RUN cycle H, with `step_mode`=0:
  - DRAIN occupies H+1..H+`DRAIN_CYCLES`.
  - DONE and `done`=1 occur in cycle H+`DRAIN_CYCLES`+1.
  - `busy` falls at H+`DRAIN_CYCLES`+2.
- Minimum `start`-to-`done` latency is `RST_CYCLES` + 1 + `DRAIN_CYCLES` + 1 cycles (halt in the first RUN cycle).
- In step mode, RUN and DRAIN advance only on cycles with `step`=1. Halt detection still occurs on any RUN cycle.

## Test plan
- **Basic run:** defaults, `number_in`=7, `cpu_pc` reaches 0x40 after 20 enabled cycles, `cpu_ans0`=0x15 and `cpu_ans1`=0x8 during drain. Required: `done` pulses once, `ans0`=0x15, `ans1`=0x8, `timeout`=0, `cycles`=20, `cpu_number`=7 throughout, `cpu_rst` high for exactly 2 cycles after start.
- **Timeout:** `MAX_CYCLES`=16, `cpu_pc` never equals 0x40. Required: DRAIN entered after 16 enabled cycles, `done` with `timeout`=1, `cycles`=16. With halt forced on the 16th enabled cycle instead, `timeout`=0.
- **Abort mid-RUN:** after a completed run (ans0=0x15), a second start with `abort` at RUN cycle 5. Required: `busy` falls the next cycle, no `done`, `ans0` still 0x15, `cycles`=5. A new start is accepted the following cycle.
- **Step mode:** `step_mode`=1, `step` pulsed every 3rd cycle, halt after 4 steps. Required: `cpu_en` high only on step cycles, `cycles`=4, DRAIN consumes 5 step pulses before `done`.
- **Start while busy and reset mid-run:** `start` pulsed during RUN is ignored and `cpu_number` is unchanged. `rst` asserted in DRAIN returns all outputs to reset values at the next edge, including `cpu_rst`=1 and `ans0`=0.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// Run controller: resets, releases and gates the CPU for one program run,
// then drains the pipeline and captures ANS0/ANS1 into result registers.
module cpu_run_ctrl #(
  parameter logic [31:0] HALT_PC      = 32'h0000_0040,
  parameter int          RST_CYCLES   = 2,
  parameter int          DRAIN_CYCLES = 5,
  parameter int          MAX_CYCLES   = 4096,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      number_in,
  input  logic             step_mode,
  input  logic             step,
  input  logic [31:0]      cpu_pc,
  input  logic [31:0]      cpu_ans0,
  input  logic [31:0]      cpu_ans1,
  output logic             cpu_rst,
  output logic             cpu_en,
  output logic [31:0]      cpu_number,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [31:0]      ans0,
  output logic [31:0]      ans1,
  output logic [CNT_W-1:0] cycles
);

  typedef enum logic [2:0] {
    S_IDLE, S_CRST, S_RUN, S_DRAIN, S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] RST_LD   = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRN_LD   = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(MAX_CYCLES - 1);

  state_t           state_q, state_d;
  logic             cpu_rst_q, cpu_rst_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic [31:0]      number_q, number_d;
  logic [31:0]      ans0_q, ans0_d;
  logic [31:0]      ans1_q, ans1_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic             active;
  logic             halt;

  assign active = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign cpu_en = active & (!step_mode | step);
  assign halt   = (cpu_pc == HALT_PC);

  always_comb begin
    state_d   = state_q;
    timeout_d = timeout_q;
    number_d  = number_q;
    ans0_d    = ans0_q;
    ans1_d    = ans1_q;
    cycles_d  = cycles_q;
    rcnt_d    = rcnt_q;
    dcnt_d    = dcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_CRST;
          number_d  = number_in;
          cycles_d  = '0;
          timeout_d = 1'b0;
          rcnt_d    = RST_LD;
        end
      end
      S_CRST: begin
        if (abort) state_d = S_IDLE;
        else if (rcnt_q == '0) state_d = S_RUN;
        else rcnt_d = rcnt_q - 1'b1;
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          if (cpu_en) cycles_d = cycles_q + 1'b1;
          // halt has priority over a coincident timeout
          if (halt) begin
            state_d = S_DRAIN;
            dcnt_d  = DRN_LD;
          end else if (cpu_en && cycles_q == CYC_LAST) begin
            state_d   = S_DRAIN;
            timeout_d = 1'b1;
            dcnt_d    = DRN_LD;
          end
        end
      end
      S_DRAIN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (cpu_en) begin
          if (dcnt_q == '0) begin
            state_d = S_DONE;
            ans0_d  = cpu_ans0;
            ans1_d  = cpu_ans1;
          end else begin
            dcnt_d = dcnt_q - 1'b1;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    cpu_rst_d = (state_d == S_IDLE) || (state_d == S_CRST);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cpu_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      number_q  <= '0;
      ans0_q    <= '0;
      ans1_q    <= '0;
      cycles_q  <= '0;
      rcnt_q    <= '0;
      dcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      cpu_rst_q <= cpu_rst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      number_q  <= number_d;
      ans0_q    <= ans0_d;
      ans1_q    <= ans1_d;
      cycles_q  <= cycles_d;
      rcnt_q    <= rcnt_d;
      dcnt_q    <= dcnt_d;
    end
  end

  assign cpu_rst    = cpu_rst_q;
  assign cpu_number = number_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign ans0       = ans0_q;
  assign ans1       = ans1_q;
  assign cycles     = cycles_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed runs with a done-triggered scoreboard.
// A second instance with MAX_CYCLES=16 covers the timeout path.
module tb_cpu_run_ctrl;

  localparam logic [31:0] HALT = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        rst, start, start_to, abort;
  logic [31:0] number_in, cpu_pc, cpu_ans0, cpu_ans1;
  logic        step_mode, step;

  logic        cpu_rst, cpu_en, busy, done, timeout;
  logic [31:0] cpu_number, ans0, ans1;
  logic [15:0] cycles;

  logic        t_cpu_rst, t_cpu_en, t_busy, t_done, t_timeout;
  logic [31:0] t_cpu_number, t_ans0, t_ans1;
  logic [15:0] t_cycles;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] num;
    logic        to;
    logic [15:0] cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  always #5 clk = ~clk;

  cpu_run_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .number_in(number_in), .step_mode(step_mode), .step(step),
    .cpu_pc(cpu_pc), .cpu_ans0(cpu_ans0), .cpu_ans1(cpu_ans1),
    .cpu_rst(cpu_rst), .cpu_en(cpu_en), .cpu_number(cpu_number),
    .busy(busy), .done(done), .timeout(timeout),
    .ans0(ans0), .ans1(ans1), .cycles(cycles)
  );

  cpu_run_ctrl #(.MAX_CYCLES(16)) dut_to (
    .clk(clk), .rst(rst), .start(start_to), .abort(abort),
    .number_in(number_in), .step_mode(step_mode), .step(step),
    .cpu_pc(cpu_pc), .cpu_ans0(cpu_ans0), .cpu_ans1(cpu_ans1),
    .cpu_rst(t_cpu_rst), .cpu_en(t_cpu_en), .cpu_number(t_cpu_number),
    .busy(t_busy), .done(t_done), .timeout(t_timeout),
    .ans0(t_ans0), .ans1(t_ans1), .cycles(t_cycles)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (done) begin
      if (q0.size() == 0) begin
        total++; bad++;
        $display("FAIL done_unexpected: got done=1 want no done");
      end else begin
        e0 = q0.pop_front();
        chk("sb_ans0", ans0, e0.a0);
        chk("sb_ans1", ans1, e0.a1);
        chk("sb_timeout", 32'(timeout), 32'(e0.to));
        chk("sb_cycles", 32'(cycles), 32'(e0.cyc));
        chk("sb_number", cpu_number, e0.num);
      end
    end
    if (t_done) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL to_done_unexpected: got done=1 want no done");
      end else begin
        e1 = q1.pop_front();
        chk("sbt_ans0", t_ans0, e1.a0);
        chk("sbt_ans1", t_ans1, e1.a1);
        chk("sbt_timeout", 32'(t_timeout), 32'(e1.to));
        chk("sbt_cycles", 32'(t_cycles), 32'(e1.cyc));
        chk("sbt_number", t_cpu_number, e1.num);
      end
    end
  end

  task automatic chk_rst;
    chk("rst_cpu_rst", 32'(cpu_rst), 1);
    chk("rst_cpu_en", 32'(cpu_en), 0);
    chk("rst_number", cpu_number, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_ans0", ans0, 0);
    chk("rst_ans1", ans1, 0);
    chk("rst_cycles", 32'(cycles), 0);
  endtask

  task automatic run(input logic [31:0] num, input int halt_at,
                     input int per, input logic [31:0] a0,
                     input logic [31:0] a1, input bit poke);
    int n, c, steps, w;
    bit en;
    q0.push_back('{a0: a0, a1: a1, num: num, to: 1'b0,
                   cyc: 16'(halt_at)});
    number_in = num; start = 1; step_mode = (per > 1); step = 0;
    cpu_pc = 0; cpu_ans0 = 32'hdead_0000; cpu_ans1 = 32'hdead_0001;
    tick;
    start = 0; number_in = 0;
    chk("crst1_rst", 32'(cpu_rst), 1);
    chk("crst1_busy", 32'(busy), 1);
    tick;
    chk("crst2_rst", 32'(cpu_rst), 1);
    tick;
    chk("run_rst", 32'(cpu_rst), 0);
    n = 0; c = 0;
    while (n < halt_at && c < 200) begin
      step = (per > 1) && (c % per == per - 1);
      en = (per <= 1) || step;
      if (en) n++;
      cpu_pc = (en && n == halt_at) ? HALT : 32'h100 + 32'(n * 4);
      start = poke && c == 2;
      number_in = (poke && c == 2) ? 32'h0000_0bad : 0;
      #1;
      chk("run_en", 32'(cpu_en), 32'(en));
      chk("run_number", cpu_number, num);
      c++;
      tick;
    end
    start = 0; number_in = 0; cpu_pc = 0;
    cpu_ans0 = a0; cpu_ans1 = a1;
    steps = 0; w = 0;
    while (!done && w < 200) begin
      step = (per > 1) && (c % per == per - 1);
      en = (per <= 1) || step;
      #1;
      chk("drain_en", 32'(cpu_en), 32'(en));
      if (en) steps++;
      c++; w++;
      tick;
    end
    chk("done_seen", 32'(done), 1);
    chk("drain_steps", 32'(steps), 5);
    chk("done_en", 32'(cpu_en), 0);
    step = 0;
    tick;
    chk("busy_low", 32'(busy), 0);
  endtask

  initial begin
    int lat, w;
    rst = 1; start = 0; start_to = 0; abort = 0; number_in = 0;
    cpu_pc = 0; cpu_ans0 = 0; cpu_ans1 = 0; step_mode = 0; step = 0;
    tick; tick;
    rst = 0;
    chk_rst();

    // basic run
    run(32'd7, 20, 1, 32'h15, 32'h8, 1'b0);

    // abort in the sixth RUN cycle: five enabled cycles counted
    number_in = 32'd9; start = 1;
    tick;
    start = 0; number_in = 0;
    tick; tick;
    repeat (5) tick;
    abort = 1;
    tick;
    abort = 0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_cpu_rst", 32'(cpu_rst), 1);
    chk("abort_ans0", ans0, 32'h15);
    chk("abort_cycles", 32'(cycles), 5);
    chk("abort_timeout", 32'(timeout), 0);

    // restart right away, with a start poked mid-RUN
    run(32'd7, 20, 1, 32'h15, 32'h8, 1'b1);

    // timeout on the MAX_CYCLES=16 instance
    q1.push_back('{a0: 32'haa, a1: 32'hbb, num: 32'd3, to: 1'b1,
                   cyc: 16'd16});
    cpu_pc = 0; cpu_ans0 = 32'haa; cpu_ans1 = 32'hbb;
    number_in = 32'd3; start_to = 1;
    tick;
    start_to = 0; number_in = 0;
    lat = 1;
    while (!t_done && lat < 100) begin
      tick;
      lat++;
    end
    chk("to_latency", 32'(lat), 24);
    tick;

    // halt on the 16th enabled cycle beats the timeout
    q1.push_back('{a0: 32'haa, a1: 32'hbb, num: 32'd4, to: 1'b0,
                   cyc: 16'd16});
    number_in = 32'd4; start_to = 1;
    tick;
    start_to = 0; number_in = 0;
    tick; tick;
    for (int i = 1; i <= 16; i++) begin
      cpu_pc = (i == 16) ? HALT : 0;
      tick;
    end
    cpu_pc = 0;
    w = 0;
    while (!t_done && w < 100) begin
      tick;
      w++;
    end
    chk("to_halt_done", 32'(t_done), 1);
    tick;

    // step mode: step every 3rd cycle, halt after 4 steps
    run(32'd3, 4, 3, 32'h33, 32'h44, 1'b0);
    step_mode = 0;

    // reset asserted in DRAIN
    number_in = 32'd5; start = 1;
    tick;
    start = 0; number_in = 0;
    tick; tick;
    cpu_pc = HALT;
    tick;
    cpu_pc = 0;
    tick;
    chk("pre_rst_busy", 32'(busy), 1);
    rst = 1;
    tick;
    rst = 0;
    chk_rst();

    repeat (10) tick;
    chk("q0_empty", 32'(q0.size()), 0);
    chk("q1_empty", 32'(q1.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
